speck_iter_core: RTL and testbench
==================================

# speck_iter_core

Iterative, parametrised SPECK block-cipher encryption engine. It replaces the fixed chain of per-round key-schedule/round instances and the external start/finished sequencer with a single reused round datapath, an on-the-fly key schedule and an internal round counter. It supports any standard SPECK word size and key length through parameters. Plaintext/key enter on a valid/ready handshake; ciphertext leaves on a valid/ready handshake with backpressure.

## Interface
- WORD, 64, word size n in bits (16, 24, 32, 48, 64); block is 2·WORD
- KEY_WORDS, 2, key words m (2..4); key is KEY_WORDS·WORD bits
- ROUNDS, 32, round count T (e.g. 22 for 32/64, 32 for 128/128)
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  plaintext/key offered
- in_ready  out  1  core can accept
- plaintext  in  2·WORD  {x, y}, x in upper half
- key  in  KEY_WORDS·WORD  {l[m-2], …, l[0], k0}, k0 in lowest word
- out_valid  out  1  ciphertext held
- out_ready  in  1  consumer takes ciphertext
- ciphertext  out  2·WORD  {x, y} after ROUNDS rounds
- busy  out  1  rounds in progress

## Operation
- Constants: ALPHA = 7, BETA = 2 when WORD==16; else ALPHA = 8, BETA = 3.
- Round function R(a, b, c): a' = (ROR(a, ALPHA) + b) mod 2^WORD XOR c; b' = ROL(b, BETA) XOR a'.
- Data round i: (x, y) ← R(x, y, k_i).
- Key schedule step i: (l_new, k_{i+1}) ← R(l[0], k_i, i), with i zero-extended to WORD. The l registers shift down: l[j] ← l[j+1] for j < m-2; l[m-2] ← l_new.
- FSM states:
  - IDLE: in_ready=1. On in_valid: load x, y, k, l[] and set rnd=0 → RUN.
  - RUN: each cycle, apply the data round with the current k and the key step with i=rnd, then rnd++. When rnd==ROUNDS-1 is processed → DONE.
  - DONE: out_valid=1. ciphertext holds {x, y}, stable while out_ready=0. On out_ready → IDLE.
- in_ready is 0 in RUN and DONE. No new input overlaps an unconsumed result.
- The key step in the final round is computed but unused; its result is don't-care.
- rnd width is $clog2(ROUNDS). It never wraps inside an operation.
- Inputs are sampled only on the accept edge. Later changes to plaintext/key have no effect.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, ciphertext=0, rnd=0, x/y/k/l=0.
- Accept on edge A (in_valid & in_ready). busy=1 from A+1. out_valid=1 from A+ROUNDS+1, i.e. latency ROUNDS+1 edges.
- Release on edge D (out_valid & out_ready). in_ready=1 and out_valid=0 from D+1. Minimum issue interval is ROUNDS+2 cycles.
- If out_ready is held high, out_valid lasts exactly one cycle.
- rst_n low mid-RUN or in DONE clears everything immediately, asynchronously. The pending result is discarded and no out_valid pulse follows.
- in_valid asserted during reset is ignored. The first accept is possible on the first edge after rst_n rises.

## Structure
- Package speck_pkg holds: state enum (IDLE, RUN, DONE), functions alpha_of(WORD)/beta_of(WORD), and ROR/ROL functions.
- Sub-module speck_round (combinational, parameter WORD) implements R. It is instantiated twice: once for the data path, once for the key schedule.
- The top level holds the FSM, round counter, x/y/k registers and the l shift register.

## Test plan
- 128/128 (WORD=64, KEY_WORDS=2, ROUNDS=32): key 0f0e0d0c0b0a0908_0706050403020100, pt 6c61766975716520_7469206564616d20 → ct a65d985179783265_7860fedf5c570d18, out_valid at A+33.
- 32/64 (WORD=16, KEY_WORDS=4, ROUNDS=22): key 1918_1110_0908_0100, pt 6574_694c → ct a868_42f2.
- Backpressure: out_ready=0 for 10 cycles after DONE → ciphertext stable, in_ready=0, in_valid ignored; out_ready=1 → in_ready=1 next cycle.
- Back-to-back: in_valid and out_ready held high with two 128/128 vectors → both correct, accepts spaced 34 cycles apart.
- Reset mid-RUN at round 10 → all outputs at reset values immediately; a fresh vector afterwards gives correct ct.
- Input change: plaintext/key altered one cycle after accept → ct still matches the captured values.

Source files
------------

// File: rtl/speck_pkg.sv
// Shared types and helpers for the iterative SPECK engine.
// The rotate helpers work on a 64-bit carrier and mask the result to the live word width.
package speck_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned MAX_WORD = 64;

  function automatic int unsigned alpha_of(input int unsigned w);
    return (w == 16) ? 7 : 8;
  endfunction

  function automatic int unsigned beta_of(input int unsigned w);
    return (w == 16) ? 2 : 3;
  endfunction

  // Rotate right by r within the low w bits; bits above w must be zero on entry.
  function automatic logic [MAX_WORD-1:0] ror(input logic [MAX_WORD-1:0] v,
                                              input int unsigned r,
                                              input int unsigned w);
    logic [MAX_WORD-1:0] mask;
    mask = (w >= MAX_WORD) ? '1 : ((MAX_WORD'(1) << w) - MAX_WORD'(1));
    return ((v >> r) | (v << (w - r))) & mask;
  endfunction

  function automatic logic [MAX_WORD-1:0] rol(input logic [MAX_WORD-1:0] v,
                                              input int unsigned r,
                                              input int unsigned w);
    return ror(v, w - r, w);
  endfunction

endpackage

// File: rtl/speck_round.sv
// One SPECK round R(a, b, c): shared by the data path and the key schedule.
module speck_round
  import speck_pkg::*;
#(
  parameter int unsigned WORD = 64
) (
  input  logic [WORD-1:0] a,
  input  logic [WORD-1:0] b,
  input  logic [WORD-1:0] c,
  output logic [WORD-1:0] a_next_c,
  output logic [WORD-1:0] b_next_c
);

  localparam int unsigned ALPHA = alpha_of(WORD);
  localparam int unsigned BETA  = beta_of(WORD);

  logic [WORD-1:0] a_ror;
  logic [WORD-1:0] b_rol;

  always_comb begin
    a_ror    = WORD'(ror(MAX_WORD'(a), ALPHA, WORD));
    b_rol    = WORD'(rol(MAX_WORD'(b), BETA, WORD));
    a_next_c = (a_ror + b) ^ c;
    b_next_c = b_rol ^ a_next_c;
  end

endmodule

// File: rtl/speck_iter_core.sv
// Iterative SPECK encryption core: one round per cycle with an on-the-fly key schedule.
// Plaintext/key are captured on accept; the ciphertext is held until the consumer takes it.
module speck_iter_core
  import speck_pkg::*;
#(
  parameter int unsigned WORD      = 64,
  parameter int unsigned KEY_WORDS = 2,
  parameter int unsigned ROUNDS    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2*WORD-1:0]         plaintext,
  input  logic [KEY_WORDS*WORD-1:0] key,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*WORD-1:0]         ciphertext,
  output logic                      busy
);

  localparam int unsigned RND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam int unsigned LW    = (KEY_WORDS - 1) * WORD;
  localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);

  state_t state;
  state_t state_nxt;

  logic [RND_W-1:0]   rnd;
  logic [WORD-1:0]    x;
  logic [WORD-1:0]    y;
  logic [WORD-1:0]    k;
  logic [LW-1:0]      l_reg;
  logic [WORD-1:0]    x_nxt;
  logic [WORD-1:0]    y_nxt;
  logic [WORD-1:0]    l_new;
  logic [WORD-1:0]    k_nxt;
  logic [WORD-1:0]    rnd_word;
  logic [LW+WORD-1:0] l_cat;
  logic [LW-1:0]      l_shift;
  logic               accept;
  logic               last_rnd;
  logic               in_ready_nxt;
  logic               out_valid_nxt;
  logic               busy_nxt;

  assign accept     = in_valid & in_ready;
  assign last_rnd   = (state == RUN) && (rnd == LAST_RND);
  assign rnd_word   = WORD'(rnd);
  // l words shift toward l[0]; the fresh word enters at the top.
  assign l_cat      = {l_new, l_reg};
  assign l_shift    = LW'(l_cat >> WORD);
  assign ciphertext = {x, y};

  speck_round #(.WORD(WORD)) u_data_round (
    .a        (x),
    .b        (y),
    .c        (k),
    .a_next_c (x_nxt),
    .b_next_c (y_nxt)
  );

  speck_round #(.WORD(WORD)) u_key_round (
    .a        (l_reg[WORD-1:0]),
    .b        (k),
    .c        (rnd_word),
    .a_next_c (l_new),
    .b_next_c (k_nxt)
  );

  // State and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
      busy      <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last_rnd)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready_nxt  = 1'b0;
    out_valid_nxt = 1'b0;
    busy_nxt      = 1'b0;
    case (state_nxt)
      IDLE:    in_ready_nxt  = 1'b1;
      RUN:     busy_nxt      = 1'b1;
      DONE:    out_valid_nxt = 1'b1;
      default: in_ready_nxt  = 1'b1;
    endcase
  end

  // Round datapath; the key step on the final round is computed but never used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd   <= '0;
      x     <= '0;
      y     <= '0;
      k     <= '0;
      l_reg <= '0;
    end else if (state == IDLE && accept) begin
      rnd   <= '0;
      x     <= plaintext[2*WORD-1:WORD];
      y     <= plaintext[WORD-1:0];
      k     <= key[WORD-1:0];
      l_reg <= key[KEY_WORDS*WORD-1:WORD];
    end else if (state == RUN) begin
      x     <= x_nxt;
      y     <= y_nxt;
      k     <= k_nxt;
      l_reg <= l_shift;
      if (!last_rnd) rnd <= rnd + RND_W'(1);
    end
  end

endmodule

// File: tb/tb_speck_iter_core.sv
// Directed bench for speck_iter_core: SPECK128/128 and SPECK32/64 instances side by side.
module tb_speck_iter_core;

  localparam logic [127:0] K1 = 128'h0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [127:0] P1 = 128'h6c61766975716520_7469206564616d20;
  localparam logic [127:0] C1 = 128'ha65d985179783265_7860fedf5c570d18;
  localparam logic [127:0] K2 = 128'h0011223344556677_8899aabbccddeeff;
  localparam logic [127:0] P2 = 128'h0123456789abcdef_fedcba9876543210;
  localparam logic [63:0]  SK = 64'h1918_1110_0908_0100;
  localparam logic [31:0]  SP = 32'h6574_694c;
  localparam logic [31:0]  SC = 32'ha868_42f2;

  logic         clk;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] plaintext, key, ciphertext;
  logic         s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
  logic [31:0]  s_plaintext, s_ciphertext;
  logic [63:0]  s_key;

  int checks;
  int errors;
  int cyc;

  speck_iter_core #(.WORD(64), .KEY_WORDS(2), .ROUNDS(32)) u_dut128 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .ciphertext(ciphertext), .busy(busy)
  );

  speck_iter_core #(.WORD(16), .KEY_WORDS(4), .ROUNDS(22)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .plaintext(s_plaintext), .key(s_key), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .ciphertext(s_ciphertext), .busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference SPECK128/128: whole key schedule expanded up front, then 32 rounds.
  function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [127:0] kk);
    logic [63:0] rk [32];
    logic [63:0] l, kr, xv, yv;
    rk[0] = kk[63:0];
    l     = kk[127:64];
    for (int i = 0; i < 31; i++) begin
      kr        = rk[i];
      l         = ({l[7:0], l[63:8]} + kr) ^ 64'(i);
      rk[i + 1] = {kr[60:0], kr[63:61]} ^ l;
    end
    xv = pt[127:64];
    yv = pt[63:0];
    for (int i = 0; i < 32; i++) begin
      xv = ({xv[7:0], xv[63:8]} + yv) ^ rk[i];
      yv = {yv[60:0], yv[63:61]} ^ xv;
    end
    return {xv, yv};
  endfunction

  task automatic offer(input logic [127:0] pt, input logic [127:0] kk);
    plaintext = pt;
    key       = kk;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    in_valid = 1'b1;
    s_in_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_flags got out_valid=%b busy=%b want 0 0", out_valid, busy);
    end
    checks++;
    if (ciphertext !== 128'd0) begin errors++; $display("FAIL reset_ct got %h want 0", ciphertext); end
    rst_n = 1'b1;
    in_valid = 1'b0;
    s_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || s_busy !== 1'b0) begin
      errors++; $display("FAIL reset_ignore_valid got busy=%b s_busy=%b want 0 0", busy, s_busy);
    end
  endtask

  task automatic test_vector_128();
    int n;
    offer(P1, K1);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL accept_flags got busy=%b in_ready=%b want 1 0", busy, in_ready);
    end
    wait_out(n);
    checks++;
    if (n != 32) begin errors++; $display("FAIL latency_128 got %0d want 32", n); end
    checks++;
    if (ciphertext !== C1) begin errors++; $display("FAIL ct_128 got %h want %h", ciphertext, C1); end
    release_out();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL release got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_vector_32_64();
    int n;
    s_plaintext = SP;
    s_key       = SK;
    s_in_valid  = 1'b1;
    @(negedge clk);
    s_in_valid  = 1'b0;
    n = 0;
    while (!s_out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 22) begin errors++; $display("FAIL latency_32 got %0d want 22", n); end
    checks++;
    if (s_ciphertext !== SC) begin errors++; $display("FAIL ct_32 got %h want %h", s_ciphertext, SC); end
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
    checks++;
    if (s_in_ready !== 1'b1) begin errors++; $display("FAIL release_32 got in_ready=%b want 1", s_in_ready); end
  endtask

  task automatic test_backpressure();
    int n;
    offer(P1, K1);
    wait_out(n);
    in_valid  = 1'b1;
    plaintext = ~P1;
    key       = ~K1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (ciphertext !== C1 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL hold_%0d got ct=%h in_ready=%b out_valid=%b want %h 0 1",
                 i, ciphertext, in_ready, out_valid, C1);
      end
    end
    in_valid = 1'b0;
    release_out();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got in_ready=%b out_valid=%b busy=%b want 1 0 0",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    int n, t1, t2;
    logic [127:0] c2;
    c2 = ref_enc(P2, K2);
    plaintext = P1;
    key       = K1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    t1 = cyc;
    @(negedge clk);
    plaintext = P2;
    key       = K2;
    wait_out(n);
    checks++;
    if (n != 32 || ciphertext !== C1) begin
      errors++; $display("FAIL b2b_first got n=%0d ct=%h want 32 %h", n, ciphertext, C1);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_pulse got out_valid=%b want 0", out_valid); end
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    t2 = cyc;
    checks++;
    if (t2 - t1 != 34) begin errors++; $display("FAIL b2b_spacing got %0d want 34", t2 - t1); end
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(n);
    checks++;
    if (ciphertext !== c2) begin errors++; $display("FAIL b2b_second got %h want %h", ciphertext, c2); end
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_end got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    bit seen;
    offer(P1, K1);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || ciphertext !== 128'd0) begin
      errors++;
      $display("FAIL midrun_reset got in_ready=%b out_valid=%b busy=%b ct=%h want 1 0 0 0",
               in_ready, out_valid, busy, ciphertext);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL stale_result got out_valid pulse want none"); end
    offer(P2, K2);
    wait_out(n);
    checks++;
    if (ciphertext !== ref_enc(P2, K2)) begin
      errors++; $display("FAIL post_reset_ct got %h want %h", ciphertext, ref_enc(P2, K2));
    end
    release_out();
  endtask

  task automatic test_input_change();
    int n;
    offer(P2, K2);
    plaintext = P1;
    key       = K1;
    wait_out(n);
    checks++;
    if (ciphertext !== ref_enc(P2, K2)) begin
      errors++; $display("FAIL input_change got %h want %h", ciphertext, ref_enc(P2, K2));
    end
    release_out();
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    cyc         = 0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    plaintext   = '0;
    key         = '0;
    s_in_valid  = 1'b0;
    s_out_ready = 1'b0;
    s_plaintext = '0;
    s_key       = '0;
    test_reset();
    test_vector_128();
    test_vector_32_64();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_input_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
